load_buffer: RTL and testbench
==============================

Name: load_buffer

Overview:
- Receiving end of the reservation-station-to-load-buffer interface: accepts issued loads (func3, address, instruction-queue index), queues them in order, and performs each as a memory read through the memory controller.
- Sign- or zero-extends the returned data per func3.
- Writes the result back into the instruction queue as ready and needing CDB broadcast.
- Flushed by the global clear (mispredict) signal.

Parameters:
- LB_LEN, 8, queue depth in entries (power of two).
- IQ_ADDR_W, 4, width of an instruction-queue index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state holds and no handshakes fire
- clear_flag_in  in  1  flush all queued and in-flight loads
- lb_load_enable_in  in  1  push one load this cycle
- lb_func3_in  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
- lb_addr_in  in  32  final byte address
- lb_pos_in_iq_in  in  IQ_ADDR_W  owning instruction-queue index
- lb_full_out  out  1  back-pressure to the reservation station
- mem_req_valid_out  out  1  read request valid
- mem_req_addr_out  out  32  request address
- mem_req_size_out  out  2  0 = byte, 1 = half, 2 = word
- mem_req_ready_in  in  1  controller accepts the request this cycle
- mem_resp_valid_in  in  1  read data valid (one-cycle pulse)
- mem_resp_data_in  in  32  raw data, little-endian, right-aligned
- iq_write_enable_out  out  1  one-cycle write-back pulse
- iq_write_idx_out  out  IQ_ADDR_W  instruction-queue index to write
- iq_write_result_out  out  32  extended load value
- iq_write_ready_out  out  1  always 1 when enable is high
- iq_write_need_cdb_out  out  1  always 1 when enable is high

Behaviour:
- Reset: queue empty (head = tail = count = 0), state IDLE, draining flag clear. All outputs are 0 except lb_full_out, which follows count.
- Nothing updates on a clk edge with rdy = 0, except reset.
- Queue: circular FIFO of {func3, addr, idx}.
  - Push when lb_load_enable_in = 1; pop when a request is accepted.
  - Push and pop in the same cycle leaves count unchanged.
  - Head and tail wrap modulo LB_LEN.
- lb_full_out = (count >= LB_LEN-1), combinational from registered count. This gives one entry of headroom for the registered reservation-station issue latency.
- A push while count == LB_LEN is ignored (protocol violation, no corruption).
- FSM states: IDLE, REQ, WAIT, WB.
  - IDLE: if count != 0 and not draining, load head into the request registers, set mem_req_valid_out = 1, go to REQ.
  - REQ: hold valid, addr and size stable until mem_req_ready_in. On accept: pop the head, drop valid, go to WAIT.
  - WAIT: on mem_resp_valid_in, compute the result and register the write-back; iq_write_enable_out = 1 for exactly one cycle (WB), then return to IDLE.
  - Minimum latency: push edge to request valid = 1 cycle; response edge to iq_write_enable_out = 1 cycle.
- Size is taken from func3[1:0]: 0 → byte, 1 → half, 2 → word.
- Extension:
  - LB: sign-extend bit 7.
  - LH: sign-extend bit 15.
  - LBU, LHU: zero-extend.
  - LW: pass through.
- clear_flag_in (highest priority; any push in the same cycle is dropped):
  - Empty the queue, drop mem_req_valid_out, suppress any pending write-back.
  - If in WAIT when the clear arrives (request already accepted), set draining. The next mem_resp_valid_in is consumed and discarded, then draining clears.
  - A response arriving in the same cycle as the clear is likewise discarded.
  - No new request issues while draining.
- Reset mid-operation behaves as a full flush, without draining; the memory controller is reset together with this block.
- Strict program order: one outstanding request at a time.

Test Plan:
1. Push LB addr 0x100 idx 3; memory returns 0x00000080 → write-back idx 3, result 0xFFFFFF80, ready = 1, need_cdb = 1, a single-cycle pulse.
2. Push LHU addr 0x202 idx 5 with data 0x0000F00F; then LW addr 0x300 idx 6 with data 0x12345678 → mem_req_size 1 then 2; results 0x0000F00F then 0x12345678, in that order.
3. Push LB_LEN-1 loads with mem_req_ready_in held 0 → lb_full_out rises when count reaches 7. Push one more → count 8, still full. A further push is ignored and count stays 8.
4. Hold mem_req_ready_in low for 5 cycles → mem_req_valid_out, addr and size stay stable throughout; the head pops only on the accept cycle.
5. Assert clear_flag_in in WAIT with 3 entries queued → count 0; the next response is discarded with no iq_write_enable_out. A load pushed afterwards completes normally.
6. Drop rdy for 4 cycles mid-REQ, then restore → no state change during the stall; the transaction then completes with correct values. Push and pop in the same cycle keeps count constant across tail wrap from 7 to 0.

Source files
------------

// File: rtl/load_buffer.sv
// Load buffer: queues issued loads in program order, performs each as a single
// outstanding memory read, extends the returned data and writes it back to the IQ.
module load_buffer #(
  parameter int unsigned LB_LEN    = 8,
  parameter int unsigned IQ_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear_flag_in,
  input  logic                 lb_load_enable_in,
  input  logic [2:0]           lb_func3_in,
  input  logic [31:0]          lb_addr_in,
  input  logic [IQ_ADDR_W-1:0] lb_pos_in_iq_in,
  output logic                 lb_full_out,
  output logic                 mem_req_valid_out,
  output logic [31:0]          mem_req_addr_out,
  output logic [1:0]           mem_req_size_out,
  input  logic                 mem_req_ready_in,
  input  logic                 mem_resp_valid_in,
  input  logic [31:0]          mem_resp_data_in,
  output logic                 iq_write_enable_out,
  output logic [IQ_ADDR_W-1:0] iq_write_idx_out,
  output logic [31:0]          iq_write_result_out,
  output logic                 iq_write_ready_out,
  output logic                 iq_write_need_cdb_out
);
  localparam int unsigned PTR_W = $clog2(LB_LEN);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LB_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LB_LEN - 1);

  typedef struct packed {
    logic [2:0]           func3;
    logic [31:0]          addr;
    logic [IQ_ADDR_W-1:0] idx;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  entry_t               fifo_q [LB_LEN];
  entry_t               fifo_d [LB_LEN];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  state_t               state_q, state_d;
  logic                 draining_q, draining_d;
  logic                 req_valid_q, req_valid_d;
  logic [31:0]          req_addr_q, req_addr_d;
  logic [2:0]           req_f3_q, req_f3_d;
  logic [IQ_ADDR_W-1:0] req_idx_q, req_idx_d;
  logic                 wb_en_q, wb_en_d;
  logic [IQ_ADDR_W-1:0] wb_idx_q, wb_idx_d;
  logic [31:0]          wb_result_q, wb_result_d;
  logic                 push, pop;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    extend = {{24{d[7]}}, d[7:0]};
      3'd1:    extend = {{16{d[15]}}, d[15:0]};
      3'd4:    extend = {24'd0, d[7:0]};
      3'd5:    extend = {16'd0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    draining_d  = draining_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_f3_d    = req_f3_q;
    req_idx_d   = req_idx_q;
    wb_en_d     = 1'b0;
    wb_idx_d    = wb_idx_q;
    wb_result_d = wb_result_q;
    pop         = 1'b0;
    push        = lb_load_enable_in && (count_q != CNT_MAX);

    if (clear_flag_in) begin
      // An accepted request still owes one response; swallow it unless it lands now.
      draining_d  = (draining_q || state_q == S_WAIT) && !mem_resp_valid_in;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      state_d     = S_IDLE;
      req_valid_d = 1'b0;
    end else begin
      if (draining_q && mem_resp_valid_in) draining_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q != '0 && !draining_q) begin
            req_valid_d = 1'b1;
            req_addr_d  = fifo_q[head_q].addr;
            req_f3_d    = fifo_q[head_q].func3;
            req_idx_d   = fifo_q[head_q].idx;
            state_d     = S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready_in) begin
            pop         = 1'b1;
            req_valid_d = 1'b0;
            state_d     = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid_in) begin
            wb_en_d     = 1'b1;
            wb_idx_d    = req_idx_q;
            wb_result_d = extend(req_f3_q, mem_resp_data_in);
            state_d     = S_WB;
          end
        end
        S_WB: state_d = S_IDLE;
      endcase
      if (push) begin
        fifo_d[tail_q] = '{func3: lb_func3_in, addr: lb_addr_in, idx: lb_pos_in_iq_in};
        tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      draining_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_f3_q    <= '0;
      req_idx_q   <= '0;
      wb_en_q     <= 1'b0;
      wb_idx_q    <= '0;
      wb_result_q <= '0;
    end else if (rdy) begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      draining_q  <= draining_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_f3_q    <= req_f3_d;
      req_idx_q   <= req_idx_d;
      wb_en_q     <= wb_en_d;
      wb_idx_q    <= wb_idx_d;
      wb_result_q <= wb_result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy) fifo_q <= fifo_d;
  end

  assign lb_full_out           = (count_q >= CNT_FULL);
  assign mem_req_valid_out     = req_valid_q;
  assign mem_req_addr_out      = req_addr_q;
  assign mem_req_size_out      = req_f3_q[1:0];
  assign iq_write_enable_out   = wb_en_q;
  assign iq_write_idx_out      = wb_idx_q;
  assign iq_write_result_out   = wb_result_q;
  assign iq_write_ready_out    = wb_en_q;
  assign iq_write_need_cdb_out = wb_en_q;
endmodule

// File: tb/tb_load_buffer.sv
// Bench for load_buffer: transaction-level queue model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_load_buffer;
  localparam int LB_LEN    = 8;
  localparam int IQ_ADDR_W = 4;

  logic                 clk = 1'b0;
  logic                 rst, rdy, clear_flag_in, lb_load_enable_in;
  logic [2:0]           lb_func3_in;
  logic [31:0]          lb_addr_in;
  logic [IQ_ADDR_W-1:0] lb_pos_in_iq_in;
  logic                 lb_full_out, mem_req_valid_out;
  logic [31:0]          mem_req_addr_out;
  logic [1:0]           mem_req_size_out;
  logic                 mem_req_ready_in  = 1'b0;
  logic                 mem_resp_valid_in = 1'b0;
  logic [31:0]          mem_resp_data_in  = '0;
  logic                 iq_write_enable_out, iq_write_ready_out, iq_write_need_cdb_out;
  logic [IQ_ADDR_W-1:0] iq_write_idx_out;
  logic [31:0]          iq_write_result_out;

  load_buffer #(.LB_LEN(LB_LEN), .IQ_ADDR_W(IQ_ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear_flag_in),
    .lb_load_enable_in(lb_load_enable_in), .lb_func3_in(lb_func3_in),
    .lb_addr_in(lb_addr_in), .lb_pos_in_iq_in(lb_pos_in_iq_in),
    .lb_full_out(lb_full_out), .mem_req_valid_out(mem_req_valid_out),
    .mem_req_addr_out(mem_req_addr_out), .mem_req_size_out(mem_req_size_out),
    .mem_req_ready_in(mem_req_ready_in), .mem_resp_valid_in(mem_resp_valid_in),
    .mem_resp_data_in(mem_resp_data_in), .iq_write_enable_out(iq_write_enable_out),
    .iq_write_idx_out(iq_write_idx_out), .iq_write_result_out(iq_write_result_out),
    .iq_write_ready_out(iq_write_ready_out), .iq_write_need_cdb_out(iq_write_need_cdb_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]           f3;
    logic [31:0]          addr;
    logic [IQ_ADDR_W-1:0] idx;
  } ld_t;

  // Reference model state: pending loads, the request on the bus, the accepted
  // load awaiting data, a pending write-back, and an owed response to discard.
  ld_t                  mq[$];
  ld_t                  m_req, m_cur;
  bit                   m_req_valid, m_wait, m_wb, m_drain;
  bit                   m_push, m_was_wb, m_was_drain;
  logic [IQ_ADDR_W-1:0] m_wb_idx;
  logic [31:0]          m_wb_res;

  int          n_checks = 0, n_fail = 0, wb_seen = 0;
  int unsigned ready_pct = 100, resp_pct = 100;
  logic [31:0] resp_data[$];
  logic [2:0]  f3tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endfunction

  function automatic logic [31:0] ext(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'd0:    return {24'd0, d[7:0]}  - (d[7]  ? 32'h100   : 32'h0);
      3'd1:    return {16'd0, d[15:0]} - (d[15] ? 32'h10000 : 32'h0);
      3'd4:    return d & 32'hFF;
      3'd5:    return d & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_req_valid = 0; m_wait = 0; m_wb = 0; m_drain = 0;
    end else if (rdy) begin
      m_push      = lb_load_enable_in && (mq.size() < LB_LEN);
      m_was_wb    = m_wb;
      m_was_drain = m_drain;
      m_wb        = 0;
      if (clear_flag_in) begin
        m_drain = (m_drain || m_wait) && !mem_resp_valid_in;
        mq.delete();
        m_req_valid = 0; m_wait = 0;
      end else begin
        if (m_drain && mem_resp_valid_in) m_drain = 0;
        if (m_req_valid) begin
          if (mem_req_ready_in) begin
            m_cur = mq.pop_front();
            m_req_valid = 0; m_wait = 1;
          end
        end else if (m_wait) begin
          if (mem_resp_valid_in) begin
            m_wait = 0; m_wb = 1;
            m_wb_idx = m_cur.idx;
            m_wb_res = ext(m_cur.f3, mem_resp_data_in);
          end
        end else if (!m_was_wb && !m_was_drain && mq.size() != 0) begin
          m_req_valid = 1;
          m_req = mq[0];
        end
        if (m_push) mq.push_back('{lb_func3_in, lb_addr_in, lb_pos_in_iq_in});
      end
    end
  end

  // Memory controller stand-in: random accept, single-cycle response pulses.
  always @(negedge clk) begin
    mem_req_ready_in = ($urandom_range(99) < ready_pct);
    if ((m_wait || m_drain) && !mem_resp_valid_in && $urandom_range(99) < resp_pct) begin
      mem_resp_valid_in = 1'b1;
      mem_resp_data_in  = (m_wait && resp_data.size() != 0) ? resp_data.pop_front() : $urandom;
    end else begin
      mem_resp_valid_in = 1'b0;
      mem_resp_data_in  = $urandom;
    end
  end

  always @(negedge clk) begin
    chk("lb_full", 32'(lb_full_out), 32'(mq.size() >= LB_LEN - 1));
    chk("req_valid", 32'(mem_req_valid_out), 32'(m_req_valid));
    if (m_req_valid) begin
      chk("req_addr", mem_req_addr_out, m_req.addr);
      chk("req_size", 32'(mem_req_size_out), 32'(m_req.f3[1:0]));
    end
    chk("wb_en", 32'(iq_write_enable_out), 32'(m_wb));
    if (m_wb) begin
      chk("wb_idx", 32'(iq_write_idx_out), 32'(m_wb_idx));
      chk("wb_result", iq_write_result_out, m_wb_res);
      chk("wb_ready", 32'(iq_write_ready_out), 32'(1));
      chk("wb_need_cdb", 32'(iq_write_need_cdb_out), 32'(1));
    end
    if (iq_write_enable_out === 1'b1) wb_seen++;
  end

  task automatic push(logic [2:0] f3, logic [31:0] addr, logic [IQ_ADDR_W-1:0] idx);
    lb_load_enable_in = 1'b1;
    lb_func3_in       = f3;
    lb_addr_in        = addr;
    lb_pos_in_iq_in   = idx;
    @(negedge clk);
    lb_load_enable_in = 1'b0;
  endtask

  task automatic expect_req(string name, logic [31:0] addr, logic [1:0] size);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req_valid_out === 1'b1) break;
    end
    if (i == 40) timeout(name);
    else begin
      chk({name, "_addr"}, mem_req_addr_out, addr);
      chk({name, "_size"}, 32'(mem_req_size_out), 32'(size));
    end
  endtask

  task automatic expect_wb(string name, logic [IQ_ADDR_W-1:0] idx, logic [31:0] res);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (iq_write_enable_out === 1'b1) break;
    end
    if (i == 40) timeout(name);
    else begin
      chk({name, "_idx"}, 32'(iq_write_idx_out), 32'(idx));
      chk({name, "_result"}, iq_write_result_out, res);
      chk({name, "_ready"}, 32'(iq_write_ready_out), 32'(1));
      chk({name, "_cdb"}, 32'(iq_write_need_cdb_out), 32'(1));
      @(negedge clk);
      chk({name, "_pulse_end"}, 32'(iq_write_enable_out), 32'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wb_base;
    rst = 1'b1; rdy = 1'b1; clear_flag_in = 1'b0; lb_load_enable_in = 1'b0;
    lb_func3_in = '0; lb_addr_in = '0; lb_pos_in_iq_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_full", 32'(lb_full_out), 32'(0));
    chk("rst_req_valid", 32'(mem_req_valid_out), 32'(0));
    chk("rst_req_addr", mem_req_addr_out, 32'(0));
    chk("rst_req_size", 32'(mem_req_size_out), 32'(0));
    chk("rst_wb_en", 32'(iq_write_enable_out), 32'(0));
    chk("rst_wb_idx", 32'(iq_write_idx_out), 32'(0));
    chk("rst_wb_result", iq_write_result_out, 32'(0));
    chk("rst_wb_ready", 32'(iq_write_ready_out), 32'(0));
    chk("rst_wb_cdb", 32'(iq_write_need_cdb_out), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Signed byte load
    resp_data.push_back(32'h0000_0080);
    push(3'd0, 32'h100, 4'd3);
    expect_wb("t1", 4'd3, 32'hFFFF_FF80);

    // Unsigned half then word, in order
    resp_data.push_back(32'h0000_F00F);
    resp_data.push_back(32'h1234_5678);
    push(3'd5, 32'h202, 4'd5);
    expect_req("t2_req_lhu", 32'h202, 2'd1);
    push(3'd2, 32'h300, 4'd6);
    expect_wb("t2_lhu", 4'd5, 32'h0000_F00F);
    expect_req("t2_req_lw", 32'h300, 2'd2);
    expect_wb("t2_lw", 4'd6, 32'h1234_5678);

    // Fill with memory stalled; full threshold, overflow drop, stable request
    ready_pct = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      push(3'd2, 32'h400 + 32'(i * 4), 4'(i));
      if (i == 5) chk("t3_full_at6", 32'(lb_full_out), 32'(0));
      if (i == 6) chk("t3_full_at7", 32'(lb_full_out), 32'(1));
      if (i >= 7) chk("t3_full_at8", 32'(lb_full_out), 32'(1));
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid_hold", 32'(mem_req_valid_out), 32'(1));
      chk("t4_addr_hold", mem_req_addr_out, 32'h400);
      chk("t4_size_hold", 32'(mem_req_size_out), 32'(2));
      @(negedge clk);
    end
    wb_base = wb_seen;
    ready_pct = 100;
    repeat (100) @(negedge clk);
    #1;
    chk("t3_wb_count", 32'(wb_seen - wb_base), 32'(8));

    // Clear while a request is outstanding with three more queued
    resp_pct = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(3'd4, 32'h700 + 32'(i), 4'(i));
    clear_flag_in = 1'b1;
    @(negedge clk);
    clear_flag_in = 1'b0;
    chk("t5_full_after_clear", 32'(lb_full_out), 32'(0));
    chk("t5_valid_after_clear", 32'(mem_req_valid_out), 32'(0));
    resp_data.push_back(32'h0000_8001);
    push(3'd1, 32'h800, 4'd9);
    repeat (3) @(negedge clk);
    chk("t5_no_issue_draining", 32'(mem_req_valid_out), 32'(0));
    wb_base = wb_seen;
    resp_pct = 100;
    expect_wb("t5_after", 4'd9, 32'hFFFF_8001);
    #1;
    chk("t5_wb_count", 32'(wb_seen - wb_base), 32'(1));

    // rdy stall in the middle of a request
    ready_pct = 0;
    @(negedge clk);
    resp_data.push_back(32'hABCD_EF90);
    push(3'd4, 32'h600, 4'd12);
    expect_req("t6_req", 32'h600, 2'd0);
    rdy = 1'b0;
    ready_pct = 100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_stall_valid", 32'(mem_req_valid_out), 32'(1));
      chk("t6_stall_addr", mem_req_addr_out, 32'h600);
      chk("t6_stall_wb", 32'(iq_write_enable_out), 32'(0));
    end
    rdy = 1'b1;
    expect_wb("t6", 4'd12, 32'h0000_0090);

    // Randomized soak
    ready_pct = 70;
    resp_pct  = 50;
    for (int c = 0; c < 3000; c++) begin
      rst               = (c == 1500);
      rdy               = ($urandom_range(9) != 0);
      clear_flag_in     = ($urandom_range(49) == 0);
      lb_load_enable_in = ($urandom_range(1) == 1);
      lb_func3_in       = f3tab[$urandom_range(4)];
      lb_addr_in        = $urandom;
      lb_pos_in_iq_in   = 4'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; rdy = 1'b1; clear_flag_in = 1'b0; lb_load_enable_in = 1'b0;
    repeat (60) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
